// File: rtl/posit_decode_arbiter_pkg.sv
// Shared types and sizing for the posit decode arbiter.
//   regime_width()  : width of the signed regime value k for an N-bit posit
//   arb_state_t     : arbiter FSM states
//   posit_fields_t  : decoded posit fields as produced by the extractor
// No ports (package).
package posit_decode_arbiter_pkg;

    localparam int unsigned PositN  = 8;
    localparam int unsigned PositEs = 3;

    // k spans -(N-1)..(N-2), which fits in clog2(N)+1 signed bits.
    function automatic int unsigned regime_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

    localparam int unsigned PositRs = regime_width(PositN);

    typedef enum logic [1:0] {
        StIdle,
        StExtract,
        StOutput
    } arb_state_t;

    typedef struct packed {
        logic                      sign;
        logic signed [PositRs-1:0] regime;
        logic [PositEs-1:0]        exp;
        logic [PositN-1:0]         frac;
        logic                      zero;
        logic                      nar;
    } posit_fields_t;

endpackage

// File: rtl/posit_decode_arbiter_if.sv
// Bundles the two requester ports and the result port of the posit decode arbiter.
//   a_valid/a_data/a_ready : requester A operand handshake
//   b_valid/b_data/b_ready : requester B operand handshake
//   out_valid/out_ready    : result handshake
//   out_id..out_nar        : decoded result fields, tagged with requester id
// Modports: master = requesters + consumer side, slave = arbiter side.
interface posit_decode_arbiter_if #(
    parameter int unsigned N  = posit_decode_arbiter_pkg::PositN,
    parameter int unsigned ES = posit_decode_arbiter_pkg::PositEs,
    parameter int unsigned RS = posit_decode_arbiter_pkg::PositRs
);
    logic                 a_valid;
    logic [N-1:0]         a_data;
    logic                 a_ready;
    logic                 b_valid;
    logic [N-1:0]         b_data;
    logic                 b_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_id;
    logic                 out_sign;
    logic signed [RS-1:0] out_regime;
    logic [ES-1:0]        out_exp;
    logic [N-1:0]         out_frac;
    logic                 out_zero;
    logic                 out_nar;

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_id, out_sign, out_regime, out_exp,
               out_frac, out_zero, out_nar
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_id, out_sign, out_regime, out_exp,
               out_frac, out_zero, out_nar
    );

endinterface

// File: rtl/posit_decode_arbiter_extract.sv
// Combinational posit field extractor.
//   operand : N-bit posit word
//   fields  : sign, signed regime k, exponent, hidden-1 left-aligned fraction, zero/NaR flags
module posit_field_extract
    import posit_decode_arbiter_pkg::*;
#(
    parameter int unsigned N  = PositN,
    parameter int unsigned ES = PositEs,
    parameter int unsigned RS = PositRs
) (
    input  logic [N-1:0]  operand,
    output posit_fields_t fields
);

    logic [N-1:0] mag;
    logic [N-2:0] body;
    logic [N-2:0] rest;
    logic         lead;
    logic         done;
    logic         is_zero;
    logic         is_nar;
    int           run;
    int           k;

    always_comb begin
        is_zero = (operand == '0);
        is_nar  = (operand == {1'b1, {(N-1){1'b0}}});
        // Negative posits decode from their two's complement magnitude.
        mag     = operand[N-1] ? -operand : operand;
        body    = mag[N-2:0];
        lead    = body[N-2];

        run  = 0;
        done = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!done) begin
                if (body[i] == lead) begin
                    run = run + 1;
                end else begin
                    done = 1'b1;
                end
            end
        end

        k = lead ? run - 1 : -run;
        // Drop the regime run plus its terminating bit; bits shifted past the end read as 0.
        rest = body << (run + 1);

        fields      = '0;
        fields.sign = operand[N-1];
        fields.zero = is_zero;
        fields.nar  = is_nar;
        if (!is_zero && !is_nar) begin
            fields.regime = RS'(k);
            fields.exp    = rest[N-2 -: ES];
            fields.frac   = {1'b1, rest[N-2-ES:0], {ES{1'b0}}};
        end
    end

endmodule

// File: rtl/posit_decode_arbiter.sv
// Round-robin arbiter sharing one posit field extractor between requesters A and B.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of posit_decode_arbiter_if (A/B operand handshakes, tagged result)
// One transaction in flight: IDLE -accept-> EXTRACT -> OUTPUT -handshake-> IDLE or EXTRACT.
module posit_decode_arbiter
    import posit_decode_arbiter_pkg::*;
#(
    parameter int unsigned N  = PositN,
    parameter int unsigned ES = PositEs,
    parameter int unsigned RS = PositRs
) (
    input logic                   clk,
    input logic                   reset,
    posit_decode_arbiter_if.slave bus
);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic          rr_ptr_q;
    logic [N-1:0]  operand_q;
    logic          id_q;
    posit_fields_t fields;
    posit_fields_t result_q;
    logic          result_id_q;

    logic          any_req;
    logic          winner;
    logic          arb_en;
    logic          accept;

    posit_field_extract #(
        .N  (N),
        .ES (ES),
        .RS (RS)
    ) u_extract (
        .operand (operand_q),
        .fields  (fields)
    );

    always_comb begin
        any_req = bus.a_valid | bus.b_valid;
        // A lone requester wins outright; contention is settled by rr_ptr.
        winner  = (bus.a_valid && bus.b_valid) ? rr_ptr_q : bus.b_valid;
        // Accept only when the result slot is free or being drained this cycle.
        arb_en  = !reset && ((state_q == StIdle) ||
                             (state_q == StOutput && bus.out_ready));
        accept  = arb_en && any_req;

        bus.a_ready = accept && !winner;
        bus.b_ready = accept && winner;

        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StExtract;
                end
            end
            StExtract: begin
                state_d = StOutput;
            end
            StOutput: begin
                if (bus.out_ready) begin
                    state_d = accept ? StExtract : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            rr_ptr_q    <= 1'b0;
            operand_q   <= '0;
            id_q        <= 1'b0;
            result_q    <= '0;
            result_id_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                operand_q <= winner ? bus.b_data : bus.a_data;
                id_q      <= winner;
                rr_ptr_q  <= ~winner;
            end
            if (state_q == StExtract) begin
                result_q    <= fields;
                result_id_q <= id_q;
            end
        end
    end

    assign bus.out_valid  = (state_q == StOutput);
    assign bus.out_id     = result_id_q;
    assign bus.out_sign   = result_q.sign;
    assign bus.out_regime = result_q.regime;
    assign bus.out_exp    = result_q.exp;
    assign bus.out_frac   = result_q.frac;
    assign bus.out_zero   = result_q.zero;
    assign bus.out_nar    = result_q.nar;

endmodule

// File: tb/tb_posit_decode_arbiter.sv
// Directed self-checking bench for posit_decode_arbiter (N=8, ES=3).
module tb_posit_decode_arbiter;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    posit_decode_arbiter_if #(.N(8), .ES(3), .RS(4)) bus ();

    posit_decode_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input bit id, input bit sign, input int k,
                              input int e, input int f, input bit z, input bit n);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_id"},    32'(bus.out_id), 32'(id));
        chk({tag, "_sign"},  32'(bus.out_sign), 32'(sign));
        chk({tag, "_k"},     32'(bus.out_regime), k);
        chk({tag, "_exp"},   32'(bus.out_exp), e);
        chk({tag, "_frac"},  32'(bus.out_frac), f);
        chk({tag, "_zero"},  32'(bus.out_zero), 32'(z));
        chk({tag, "_nar"},   32'(bus.out_nar), 32'(n));
    endtask

    // Offer one operand from a single requester (out_ready assumed high), check the result.
    task automatic single(input string tag, input bit which, input logic [7:0] data,
                          input bit sign, input int k, input int e, input int f);
        bit got;
        int n;
        if (which) begin
            bus.b_valid = 1'b1;
            bus.b_data  = data;
        end else begin
            bus.a_valid = 1'b1;
            bus.a_data  = data;
        end
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            #1;
            got = which ? bus.b_ready : bus.a_ready;
            @(negedge clk);
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        chk({tag, "_accept"}, 32'(got), 32'd1);
        n = 0;
        while (!bus.out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        expect_out(tag, which, sign, k, e, f, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        reset         = 1'b1;
        bus.a_valid   = 1'b0;
        bus.a_data    = '0;
        bus.b_valid   = 1'b0;
        bus.b_data    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_a_ready",   32'(bus.a_ready), 32'd0);
        chk("rst_b_ready",   32'(bus.b_ready), 32'd0);
        chk("rst_out_id",    32'(bus.out_id), 32'd0);
        chk("rst_out_frac",  32'(bus.out_frac), 32'd0);
        chk("rst_out_k",     32'(bus.out_regime), 32'd0);
        chk("rst_out_zero",  32'(bus.out_zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: A sends 0x40, two-cycle latency
        bus.a_valid   = 1'b1;
        bus.a_data    = 8'h40;
        bus.out_ready = 1'b1;
        #1;
        chk("t1_a_ready", 32'(bus.a_ready), 32'd1);
        chk("t1_b_ready", 32'(bus.b_ready), 32'd0);
        @(negedge clk);
        bus.a_valid = 1'b0;
        #1;
        chk("t1_lat1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        expect_out("t1", 1'b0, 1'b0, 0, 0, 8'h80, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("t1_drained", 32'(bus.out_valid), 32'd0);
        @(negedge clk);

        // 2: A=0x00 and B=0x80 together from reset
        reset = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        bus.a_valid = 1'b1;
        bus.a_data  = 8'h00;
        bus.b_valid = 1'b1;
        bus.b_data  = 8'h80;
        #1;
        chk("t2_a_ready", 32'(bus.a_ready), 32'd1);
        chk("t2_b_ready", 32'(bus.b_ready), 32'd0);
        @(negedge clk);
        bus.a_valid = 1'b0;
        #1;
        chk("t2_b_wait", 32'(bus.b_ready), 32'd0);
        @(negedge clk);
        expect_out("t2_a", 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        #1;
        chk("t2_b_go", 32'(bus.b_ready), 32'd1);
        @(negedge clk);
        bus.b_valid = 1'b0;
        #1;
        chk("t2_gap", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        expect_out("t2_b", 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b1);
        @(negedge clk);

        // 3, 4: single-requester decodes
        single("t3_c0", 1'b1, 8'hC0, 1'b1, 0, 0, 8'h80);
        single("t3_7f", 1'b1, 8'h7F, 1'b0, 6, 0, 8'h80);
        single("t4_01", 1'b0, 8'h01, 1'b0, -6, 0, 8'h80);
        single("t4_5a", 1'b0, 8'h5A, 1'b0, 0, 6, 8'hC0);

        // 5: both requesters continuously valid
        reset = 1'b1;
        @(negedge clk);
        reset         = 1'b0;
        bus.a_valid   = 1'b1;
        bus.a_data    = 8'h40;
        bus.b_valid   = 1'b1;
        bus.b_data    = 8'hC0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            chk("t5_excl", 32'(bus.a_ready && bus.b_ready), 32'd0);
            chk("t5_valid", 32'(bus.out_valid), 32'(c % 2 == 0 && c > 0));
            if (c % 2 == 0 && c > 0) begin
                chk("t5_id",   32'(bus.out_id), 32'((c / 2 - 1) % 2));
                chk("t5_sign", 32'(bus.out_sign), 32'((c / 2 - 1) % 2));
            end
            @(negedge clk);
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;

        // 6: stall with a pending result, then reset mid-EXTRACT
        reset = 1'b1;
        @(negedge clk);
        reset         = 1'b0;
        bus.out_ready = 1'b0;
        bus.a_valid   = 1'b1;
        bus.a_data    = 8'h5A;
        #1;
        chk("t6_acc", 32'(bus.a_ready), 32'd1);
        @(negedge clk);
        bus.a_valid = 1'b0;
        @(negedge clk);
        bus.a_valid = 1'b1;
        bus.a_data  = 8'h01;
        bus.b_valid = 1'b1;
        bus.b_data  = 8'h7F;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t6_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("t6_hold_id",    32'(bus.out_id), 32'd0);
            chk("t6_hold_exp",   32'(bus.out_exp), 32'd6);
            chk("t6_hold_frac",  32'(bus.out_frac), 32'hC0);
            chk("t6_hold_a_rdy", 32'(bus.a_ready), 32'd0);
            chk("t6_hold_b_rdy", 32'(bus.b_ready), 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("t6_rr_b",   32'(bus.b_ready), 32'd1);
        chk("t6_rr_a",   32'(bus.a_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rst_frac",  32'(bus.out_frac), 32'd0);
        chk("t6_rst_a_rdy", 32'(bus.a_ready), 32'd1);
        chk("t6_rst_b_rdy", 32'(bus.b_ready), 32'd0);
        @(negedge clk);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        #1;
        chk("t6_discard", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        expect_out("t6_after", 1'b0, 1'b0, -6, 0, 8'h80, 1'b0, 1'b0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
